// File: rtl/dashboard_sensor_input.sv
// Door/seat-belt switch conditioner: 2-flop synchronizer, per-bit debounce and a
// lowest-index-first change-event stream with valid/ready handshake.
module dashboard_sensor_input #(
  parameter int N_SENSORS       = 6,
  parameter int DEBOUNCE_CYCLES = 1000000,
  localparam int IDX_W = (N_SENSORS > 1) ? $clog2(N_SENSORS) : 1,
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic [N_SENSORS-1:0] raw,
  output logic [N_SENSORS-1:0] state,
  output logic                 event_valid,
  input  logic                 event_ready,
  output logic [IDX_W-1:0]     event_index,
  output logic                 event_level
);

  logic [N_SENSORS-1:0] sync1_reg;
  logic [N_SENSORS-1:0] sync_reg;
  logic [N_SENSORS-1:0] state_vec;
  logic [N_SENSORS-1:0] commit;
  logic [N_SENSORS-1:0] pending_reg;
  logic [N_SENSORS-1:0] pending_next;
  logic [N_SENSORS-1:0] sel_onehot;
  logic [N_SENSORS-1:0] clear_mask;
  logic [IDX_W-1:0]     sel_idx;
  logic                 load;
  logic                 valid_reg;
  logic [IDX_W-1:0]     index_reg;
  logic                 level_reg;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync1_reg <= '0;
      sync_reg  <= '0;
    end else begin
      sync1_reg <= raw;
      sync_reg  <= sync1_reg;
    end
  end

  // A counter only runs while the synchronized level disagrees with state,
  // so any glitch back restarts it and the terminal count never wraps.
  for (genvar gi = 0; gi < N_SENSORS; gi++) begin : g_debounce
    logic [CNT_W-1:0] cnt_reg;
    logic             state_bit_reg;

    assign commit[gi] = (sync_reg[gi] != state_bit_reg) &&
                        (cnt_reg == CNT_W'(DEBOUNCE_CYCLES - 1));
    assign state_vec[gi] = state_bit_reg;

    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        cnt_reg       <= '0;
        state_bit_reg <= 1'b0;
      end else if (sync_reg[gi] == state_bit_reg) begin
        cnt_reg <= '0;
      end else if (commit[gi]) begin
        cnt_reg       <= '0;
        state_bit_reg <= sync_reg[gi];
      end else begin
        cnt_reg <= cnt_reg + 1'b1;
      end
    end
  end

  always_comb begin
    sel_idx    = '0;
    sel_onehot = '0;
    for (int i = N_SENSORS - 1; i >= 0; i--) begin
      if (pending_reg[i]) begin
        sel_idx       = IDX_W'(i);
        sel_onehot    = '0;
        sel_onehot[i] = 1'b1;
      end
    end
  end

  assign load       = (!valid_reg || event_ready) && (pending_reg != '0);
  assign clear_mask = load ? sel_onehot : '0;
  // A commit on the same edge as its clear must survive, so the set is applied last.
  assign pending_next = (pending_reg & ~clear_mask) | commit;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pending_reg <= '0;
      valid_reg   <= 1'b0;
      index_reg   <= '0;
      level_reg   <= 1'b0;
    end else begin
      pending_reg <= pending_next;
      if (load) begin
        valid_reg <= 1'b1;
        index_reg <= sel_idx;
        level_reg <= |(state_vec & sel_onehot);
      end else if (event_ready) begin
        valid_reg <= 1'b0;
      end
    end
  end

  assign state       = state_vec;
  assign event_valid = valid_reg;
  assign event_index = index_reg;
  assign event_level = level_reg;

endmodule

// File: tb/tb_dashboard_sensor_input.sv
// Bench for dashboard_sensor_input: directed scenarios plus random switch activity,
// compared every cycle against a timestamp-based behavioural model.
module tb_dashboard_sensor_input;

  localparam int N   = 6;
  localparam int DEB = 4;
  localparam int IW  = 3;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic [N-1:0]  raw = '0;
  logic          event_ready = 1'b1;
  logic [N-1:0]  state;
  logic          event_valid;
  logic [IW-1:0] event_index;
  logic          event_level;

  int n_checks = 0;
  int n_errors = 0;

  dashboard_sensor_input #(.N_SENSORS(N), .DEBOUNCE_CYCLES(DEB)) dut (
    .clock(clock), .reset_n(reset_n), .raw(raw), .state(state),
    .event_valid(event_valid), .event_ready(event_ready),
    .event_index(event_index), .event_level(event_level)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: state follows sync once sync has disagreed for DEB consecutive edges
  // since the last agreement or commit (tracked as an edge timestamp).
  logic [N-1:0] m_sync1 = '0, m_sync = '0, m_state = '0, m_pend = '0;
  logic [N-1:0] m_set, m_clr, m_st_old;
  int           m_agree [N];
  int           m_cyc = 0;
  int           m_k;
  logic         m_valid = 1'b0;
  int           m_idx = 0;
  logic         m_level = 1'b0;

  initial begin
    forever begin
      @(posedge clock or negedge reset_n);
      if (!reset_n) begin
        m_sync1 = '0; m_sync = '0; m_state = '0; m_pend = '0;
        m_valid = 1'b0; m_idx = 0; m_level = 1'b0; m_cyc = 0;
        for (int i = 0; i < N; i++) m_agree[i] = 0;
      end else begin
        m_cyc++;
        m_st_old = m_state;
        m_set = '0;
        m_clr = '0;
        for (int i = 0; i < N; i++) begin
          if (m_sync[i] == m_st_old[i]) m_agree[i] = m_cyc;
          else if (m_cyc - m_agree[i] == DEB) begin
            m_state[i] = m_sync[i];
            m_agree[i] = m_cyc;
            m_set[i]   = 1'b1;
          end
        end
        m_k = -1;
        for (int i = N - 1; i >= 0; i--) if (m_pend[i]) m_k = i;
        if ((!m_valid || event_ready) && m_k >= 0) begin
          m_valid = 1'b1;
          m_idx   = m_k;
          m_level = m_st_old[m_k];
          m_clr[m_k] = 1'b1;
        end else if (m_valid && event_ready) begin
          m_valid = 1'b0;
        end
        m_pend  = (m_pend & ~m_clr) | m_set;
        m_sync  = m_sync1;
        m_sync1 = raw;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clock);
      chk("state", 32'(state), 32'(m_state));
      chk("valid", 32'(event_valid), 32'(m_valid));
      chk("index", 32'(event_index), 32'(m_idx));
      chk("level", 32'(event_level), 32'(m_level));
    end
  end

  // Log of accepted events: index*2+level, with the edge number of acceptance.
  int log_q[$];
  int cyc_q[$];
  int exp_q[$];
  int tb_cyc = 0;

  initial begin
    forever begin
      @(posedge clock);
      tb_cyc++;
      if (reset_n && event_valid && event_ready) begin
        log_q.push_back(int'(event_index) * 2 + int'(event_level));
        cyc_q.push_back(tb_cyc);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic check_log(input string name);
    chk({name, "_count"}, 32'(log_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < log_q.size(); i++)
      chk({name, "_event"}, 32'(log_q[i]), 32'(exp_q[i]));
    log_q.delete();
    cyc_q.delete();
    exp_q.delete();
  endtask

  initial begin
    // Reset with all switches open
    raw = 6'h3F;
    event_ready = 1'b1;
    tick(3);
    chk("rst_state", 32'(state), 32'h0);
    chk("rst_valid", 32'(event_valid), 32'h0);
    reset_n = 1'b1;
    tick(5);
    chk("rst_state_c5", 32'(state), 32'h0);
    tick(1);
    chk("rst_state_c6", 32'(state), 32'h3F);
    tick(8);
    for (int i = 0; i < N; i++) exp_q.push_back(i * 2 + 1);
    for (int i = 1; i < cyc_q.size(); i++)
      chk("rst_consecutive", 32'(cyc_q[i] - cyc_q[0]), 32'(i));
    check_log("rst_events");
    raw = '0;
    tick(14);
    for (int i = 0; i < N; i++) exp_q.push_back(i * 2);
    check_log("rst_release_events");

    // Bounce on belt-side bit 2
    for (int t = 0; t < 10; t++) begin
      raw[2] = ~raw[2];
      for (int c = 0; c < 3; c++) begin
        tick(1);
        chk("bounce_hold", 32'(state[2]), 32'h0);
      end
    end
    raw[2] = 1'b1;
    tick(5);
    chk("bounce_c5", 32'(state[2]), 32'h0);
    tick(1);
    chk("bounce_c6", 32'(state[2]), 32'h1);
    tick(8);
    exp_q.push_back(2 * 2 + 1);
    check_log("bounce_events");

    // Backpressure with two simultaneous changes
    event_ready = 1'b0;
    raw[0] = 1'b1;
    raw[5] = 1'b1;
    tick(7);
    for (int c = 0; c < 10; c++) begin
      chk("bp_valid", 32'(event_valid), 32'h1);
      chk("bp_index", 32'(event_index), 32'h0);
      chk("bp_level", 32'(event_level), 32'h1);
      tick(1);
    end
    event_ready = 1'b1;
    tick(1);
    chk("bp_next_valid", 32'(event_valid), 32'h1);
    chk("bp_next_index", 32'(event_index), 32'h5);
    tick(1);
    chk("bp_drain_valid", 32'(event_valid), 32'h0);
    exp_q.push_back(0 * 2 + 1);
    exp_q.push_back(5 * 2 + 1);
    check_log("bp_events");

    // Coalesce: bit 3 rises and falls while bit 0's event occupies the output
    event_ready = 1'b0;
    raw[0] = 1'b0;
    raw[3] = 1'b1;
    tick(10);
    raw[3] = 1'b0;
    tick(10);
    event_ready = 1'b1;
    tick(5);
    exp_q.push_back(0 * 2 + 0);
    exp_q.push_back(3 * 2 + 0);
    check_log("coalesce_events");

    // Re-pend: bit 1 changes again after its event is loaded
    event_ready = 1'b0;
    raw[1] = 1'b1;
    tick(8);
    raw[1] = 1'b0;
    tick(8);
    event_ready = 1'b1;
    tick(4);
    exp_q.push_back(1 * 2 + 1);
    exp_q.push_back(1 * 2 + 0);
    check_log("repend_events");

    // Reset while an event is presented and a counter is mid-count
    event_ready = 1'b0;
    raw[4] = 1'b1;
    tick(7);
    chk("mid_valid_before", 32'(event_valid), 32'h1);
    raw[2] = 1'b0;
    tick(3);
    #2 reset_n = 1'b0;
    #1;
    chk("mid_valid_now", 32'(event_valid), 32'h0);
    chk("mid_state_now", 32'(state), 32'h0);
    chk("mid_index_now", 32'(event_index), 32'h0);
    raw = '0;
    event_ready = 1'b1;
    tick(3);
    reset_n = 1'b1;
    tick(20);
    chk("mid_state_after", 32'(state), 32'h0);
    check_log("mid_no_stale");

    // Random switch activity and random backpressure
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++)
        if ($urandom_range(0, 15) == 0) raw[i] = ~raw[i];
      event_ready = ($urandom_range(0, 3) != 0);
      tick(1);
    end
    raw = '0;
    event_ready = 1'b1;
    tick(20);
    chk("final_state", 32'(state), 32'h0);
    chk("final_valid", 32'(event_valid), 32'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
